// File: rtl/mem_wb_reg_pkg.sv
// Shared definitions for the MEM/WB pipeline register: memory-op encodings,
// FSM state constants, the register field bundle and a few helpers.
package mem_wb_reg_pkg;

    // Width of the memory-op field carried down the pipeline.
    localparam int unsigned MMOP_W = 4;

    typedef enum logic [MMOP_W-1:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LB  = 4'd1,
        MEMOP_LBU = 4'd2,
        MEMOP_LH  = 4'd3,
        MEMOP_LHU = 4'd4,
        MEMOP_LW  = 4'd5,
        MEMOP_SB  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SW  = 4'd8
    } memop_e;

    // Load-response tracking FSM. Kept as plain constants so older code that
    // compares against raw 2-bit values keeps working.
    localparam logic [1:0] STATE_IDLE  = 2'd0;  // register holds a resolved result
    localparam logic [1:0] STATE_WAIT  = 2'd1;  // load issued, response still owed
    localparam logic [1:0] STATE_DRAIN = 2'd2;  // load flushed, response still owed

    // One instruction's worth of MEM/WB state.
    typedef struct packed {
        logic [MMOP_W-1:0] memop;
        logic              wren;
        logic [31:0]       waddr;
        logic [31:0]       wdata;
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [31:0]       addr;
        logic [31:0]       mem_data;
    } wb_regs_t;

    // True for every op whose result comes back from the data RAM.
    function automatic logic is_load(logic [MMOP_W-1:0] op);
        logic res;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW: res = 1'b1;
            default:                                            res = 1'b0;
        endcase
        return res;
    endfunction

    // Contents after reset: everything zero except the PC.
    function automatic wb_regs_t wb_regs_reset(logic [31:0] reset_pc);
        wb_regs_t r;
        r    = '0;
        r.pc = reset_pc;
        return r;
    endfunction

    // A bubble kills the instruction but leaves the data-side fields alone;
    // with wren=0 and memop=NOP nothing downstream looks at them.
    function automatic wb_regs_t wb_regs_bubble(wb_regs_t cur, logic [31:0] reset_pc);
        wb_regs_t r;
        r       = cur;
        r.wren  = 1'b0;
        r.memop = MEMOP_NOP;
        r.inst  = 32'h0;
        r.pc    = reset_pc;
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_reg_load_fmt.sv
// Load data formatter: picks the addressed byte/half out of a little-endian
// read word and sign- or zero-extends it. Purely combinational so it can be
// reused wherever raw RAM words need shaping.
module mem_wb_reg_load_fmt
    import mem_wb_reg_pkg::*;
(
    input  logic [MMOP_W-1:0] memop_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       rdata_i,
    output logic [31:0]       result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the low address bits; alignment is not checked here.
    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension per load flavour; non-load ops pass the word through.
    always_comb begin
        result_o = rdata_i;
        case (memop_i)
            MEMOP_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: result_o = {24'h0, byte_sel};
            MEMOP_LH:  result_o = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: result_o = {16'h0, half_sel};
            MEMOP_LW:  result_o = rdata_i;
            default:   result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Holds one instruction's result; for loads it waits
// for the late data-RAM response, formats it and only then lets the regfile
// write happen. While a response is owed it asks the pipeline to stall.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [MMOP_W-1:0] mem_memop_i,
    input  logic              mem_wren_i,
    input  logic [31:0]       mem_waddr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [31:0]       mem_inst_i,
    input  logic [31:0]       mem_pc_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_rvalid_i,
    output logic [MMOP_W-1:0] wb_memop_o,
    output logic              wb_wren_o,
    output logic [31:0]       wb_waddr_o,
    output logic [31:0]       wb_wdata_o,
    output logic [31:0]       wb_inst_o,
    output logic [31:0]       wb_pc_o,
    output logic [31:0]       wb_mem_addr_o,
    output logic [31:0]       wb_mem_data_o,
    output logic              stallreq_o
);

    wb_regs_t    regs_q, regs_d;
    wb_regs_t    captured;
    wb_regs_t    bubble;
    logic [1:0]  state_q, state_d;
    logic [31:0] load_result;

    // The formatter always looks at the op/address already sitting in the
    // register, so the response is shaped for the load we are waiting on.
    mem_wb_reg_load_fmt u_load_fmt (
        .memop_i  (regs_q.memop),
        .addr_i   (regs_q.addr[1:0]),
        .rdata_i  (data_rdata_i),
        .result_o (load_result)
    );

    // Candidate register contents for a capture and for a bubble.
    always_comb begin
        captured          = regs_q;
        captured.memop    = mem_memop_i;
        captured.wren     = mem_wren_i;
        captured.waddr    = mem_waddr_i;
        captured.wdata    = mem_wdata_i;
        captured.inst     = mem_inst_i;
        captured.pc       = mem_pc_i;
        captured.addr     = mem_addr_i;
        bubble            = wb_regs_bubble(regs_q, RESET_PC);
    end

    // Next-state and next-register selection.
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (flush_i) begin
                    regs_d = bubble;
                end else if (!stall_i) begin
                    regs_d = captured;
                    if (is_load(mem_memop_i)) begin
                        state_d = STATE_WAIT;
                    end
                end
            end
            STATE_WAIT: begin
                // Register is frozen here regardless of stall_i: the slot is
                // still owned by the outstanding load.
                if (data_rvalid_i) begin
                    state_d = STATE_IDLE;
                    if (flush_i) begin
                        regs_d = bubble;
                    end else begin
                        regs_d.wdata    = load_result;
                        regs_d.mem_data = data_rdata_i;
                    end
                end else if (flush_i) begin
                    regs_d  = bubble;
                    state_d = STATE_DRAIN;
                end
            end
            STATE_DRAIN: begin
                // Swallow the orphaned response; hold the bubble until then.
                if (data_rvalid_i) begin
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and register fields, async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= wb_regs_reset(RESET_PC);
            state_q <= STATE_IDLE;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
        end
    end

    // Outputs depend on state only, never combinationally on data_rvalid_i.
    always_comb begin
        wb_memop_o    = regs_q.memop;
        wb_wren_o     = regs_q.wren & (state_q == STATE_IDLE);
        wb_waddr_o    = regs_q.waddr;
        wb_wdata_o    = regs_q.wdata;
        wb_inst_o     = regs_q.inst;
        wb_pc_o       = regs_q.pc;
        wb_mem_addr_o = regs_q.addr;
        wb_mem_data_o = regs_q.mem_data;
        stallreq_o    = (state_q == STATE_WAIT) | (state_q == STATE_DRAIN);
    end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg with an abstract reference model.
module tb_mem_wb_reg;
    import mem_wb_reg_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall_i, flush_i;
    logic [MMOP_W-1:0] mem_memop_i;
    logic              mem_wren_i;
    logic [31:0]       mem_waddr_i, mem_wdata_i, mem_inst_i, mem_pc_i, mem_addr_i;
    logic [31:0]       data_rdata_i;
    logic              data_rvalid_i;
    logic [MMOP_W-1:0] wb_memop_o;
    logic              wb_wren_o;
    logic [31:0]       wb_waddr_o, wb_wdata_o, wb_inst_o, wb_pc_o, wb_mem_addr_o, wb_mem_data_o;
    logic              stallreq_o;

    int total = 0;
    int bad   = 0;
    int n_ins = 0;

    mem_wb_reg #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .mem_memop_i   (mem_memop_i),
        .mem_wren_i    (mem_wren_i),
        .mem_waddr_i   (mem_waddr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_inst_i    (mem_inst_i),
        .mem_pc_i      (mem_pc_i),
        .mem_addr_i    (mem_addr_i),
        .data_rdata_i  (data_rdata_i),
        .data_rvalid_i (data_rvalid_i),
        .wb_memop_o    (wb_memop_o),
        .wb_wren_o     (wb_wren_o),
        .wb_waddr_o    (wb_waddr_o),
        .wb_wdata_o    (wb_wdata_o),
        .wb_inst_o     (wb_inst_o),
        .wb_pc_o       (wb_pc_o),
        .wb_mem_addr_o (wb_mem_addr_o),
        .wb_mem_data_o (wb_mem_data_o),
        .stallreq_o    (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting from plain arithmetic on the lane index.
    function automatic logic [31:0] model_fmt(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] rd);
        int unsigned a, b, h;
        logic [31:0] r;
        a = addr % 4;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        if (op == MEMOP_LB)       r = (b >= 128) ? (b + 32'hFFFF_FF00) : b;
        else if (op == MEMOP_LBU) r = b;
        else if (op == MEMOP_LH)  r = (h >= 32768) ? (h + 32'hFFFF_0000) : h;
        else if (op == MEMOP_LHU) r = h;
        else                      r = rd;
        return r;
    endfunction

    function automatic bit model_is_load(input logic [3:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LW);
    endfunction

    // Model: instruction fields plus two flags saying whether a response is
    // owed and whether it will be kept or thrown away.
    logic [3:0]  m_memop;
    logic        m_wren;
    logic [31:0] m_waddr, m_wdata, m_inst, m_pc, m_addr, m_mdata;
    bit          m_owed_keep, m_owed_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_memop <= 4'd0; m_wren <= 1'b0; m_waddr <= '0; m_wdata <= '0;
            m_inst <= '0; m_pc <= RST_PC; m_addr <= '0; m_mdata <= '0;
            m_owed_keep <= 1'b0; m_owed_drop <= 1'b0;
        end else if (m_owed_keep) begin
            if (data_rvalid_i) begin
                m_owed_keep <= 1'b0;
                if (flush_i) begin
                    m_wren <= 1'b0; m_memop <= 4'd0; m_inst <= '0; m_pc <= RST_PC;
                end else begin
                    m_wdata <= model_fmt(m_memop, m_addr, data_rdata_i);
                    m_mdata <= data_rdata_i;
                end
            end else if (flush_i) begin
                m_wren <= 1'b0; m_memop <= 4'd0; m_inst <= '0; m_pc <= RST_PC;
                m_owed_keep <= 1'b0;
                m_owed_drop <= 1'b1;
            end
        end else if (m_owed_drop) begin
            if (data_rvalid_i) m_owed_drop <= 1'b0;
        end else if (flush_i) begin
            m_wren <= 1'b0; m_memop <= 4'd0; m_inst <= '0; m_pc <= RST_PC;
        end else if (!stall_i) begin
            m_memop <= mem_memop_i; m_wren <= mem_wren_i; m_waddr <= mem_waddr_i;
            m_wdata <= mem_wdata_i; m_inst <= mem_inst_i; m_pc <= mem_pc_i;
            m_addr <= mem_addr_i;
            m_owed_keep <= model_is_load(mem_memop_i);
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("memop", 32'(wb_memop_o), 32'(m_memop));
        check("wren", 32'(wb_wren_o), 32'(m_wren && !m_owed_keep && !m_owed_drop));
        check("waddr", wb_waddr_o, m_waddr);
        check("wdata", wb_wdata_o, m_wdata);
        check("inst", wb_inst_o, m_inst);
        check("pc", wb_pc_o, m_pc);
        check("mem_addr", wb_mem_addr_o, m_addr);
        check("mem_data", wb_mem_data_o, m_mdata);
        check("stallreq", 32'(stallreq_o), 32'(m_owed_keep || m_owed_drop));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic wren, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] addr);
        n_ins++;
        mem_memop_i = op;
        mem_wren_i  = wren;
        mem_waddr_i = waddr;
        mem_wdata_i = wdata;
        mem_addr_i  = addr;
        mem_inst_i  = 32'hA000_0000 + n_ins;
        mem_pc_i    = 32'h8000_0000 + 4 * n_ins;
    endtask

    // One-cycle-latency load patterns: op, address, read word, formatted result.
    logic [3:0]  t_op   [6] = '{MEMOP_LHU, MEMOP_LH, MEMOP_LBU, MEMOP_LB, MEMOP_LW, MEMOP_LH};
    logic [31:0] t_addr [6] = '{32'h2002, 32'h0, 32'h3, 32'h2, 32'h4, 32'h2};
    logic [31:0] t_rd   [6] = '{32'hBEEF_0000, 32'h1234_8001, 32'hA500_0000,
                                32'h007F_0000, 32'hCAFE_BABE, 32'h7FFF_0000};
    logic [31:0] t_exp  [6] = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00A5,
                                32'h0000_007F, 32'hCAFE_BABE, 32'h0000_7FFF};

    initial begin
        rst_n = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        drive(MEMOP_NOP, 1'b0, 0, 0, 0);
        #1 rst_n = 1'b0;
        tick(); tick();
        check("reset_pc", wb_pc_o, RST_PC);
        check("reset_wren", 32'(wb_wren_o), 0);
        check("reset_stallreq", 32'(stallreq_o), 0);
        rst_n = 1'b1;

        // ALU result visible the next cycle.
        drive(MEMOP_NOP, 1'b1, 5, 32'h1234, 0);
        tick();
        check("alu_wren", 32'(wb_wren_o), 1);
        check("alu_wdata", wb_wdata_o, 32'h1234);
        check("alu_waddr", wb_waddr_o, 5);
        check("alu_stallreq", 32'(stallreq_o), 0);

        // LB with response two cycles after capture.
        drive(MEMOP_LB, 1'b1, 8, 32'hDEAD, 32'h1001);
        tick();
        drive(MEMOP_NOP, 1'b0, 0, 0, 0);
        check("lb_stall1", 32'(stallreq_o), 1);
        check("lb_wren_hidden", 32'(wb_wren_o), 0);
        tick();
        check("lb_stall2", 32'(stallreq_o), 1);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_8000;
        tick();
        data_rvalid_i = 1'b0;
        check("lb_wdata", wb_wdata_o, 32'hFFFF_FF80);
        check("lb_wren", 32'(wb_wren_o), 1);
        check("lb_stall_done", 32'(stallreq_o), 0);
        check("lb_raw", wb_mem_data_o, 32'h0000_8000);

        // Table of loads answered one cycle after capture.
        for (int i = 0; i < 6; i++) begin
            drive(t_op[i], 1'b1, 9 + i, 32'h0, t_addr[i]);
            tick();
            drive(MEMOP_NOP, 1'b0, 0, 0, 0);
            data_rvalid_i = 1'b1; data_rdata_i = t_rd[i];
            tick();
            data_rvalid_i = 1'b0;
            check($sformatf("load%0d_wdata", i), wb_wdata_o, t_exp[i]);
            check($sformatf("load%0d_wren", i), 32'(wb_wren_o), 1);
        end

        // Stall holds, flush in IDLE loads a bubble.
        drive(MEMOP_NOP, 1'b1, 3, 32'h77, 0);
        tick();
        stall_i = 1'b1;
        drive(MEMOP_NOP, 1'b1, 4, 32'h88, 0);
        tick();
        check("stall_hold", wb_wdata_o, 32'h77);
        stall_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_wren", 32'(wb_wren_o), 0);
        check("flush_pc", wb_pc_o, RST_PC);
        check("flush_inst", wb_inst_o, 0);

        // LW flushed while waiting: drain the orphaned response.
        drive(MEMOP_LW, 1'b1, 7, 0, 32'h100);
        tick();
        flush_i = 1'b1;
        drive(MEMOP_NOP, 1'b0, 0, 0, 0);
        tick();
        flush_i = 1'b0;
        check("drain_stall", 32'(stallreq_o), 1);
        check("drain_wren", 32'(wb_wren_o), 0);
        drive(MEMOP_NOP, 1'b1, 6, 32'h3333, 0);
        tick();
        check("drain_blocked", wb_inst_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("drain_flush_stall", 32'(stallreq_o), 1);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h9999_9999;
        tick();
        data_rvalid_i = 1'b0;
        check("drain_done", 32'(stallreq_o), 0);
        check("drain_discard", 32'(wb_mem_data_o == 32'h9999_9999), 0);
        tick();
        check("after_drain_wdata", wb_wdata_o, 32'h3333);

        // Flush and response in the same cycle while waiting.
        drive(MEMOP_LW, 1'b1, 2, 0, 32'h0);
        tick();
        drive(MEMOP_NOP, 1'b0, 0, 0, 0);
        flush_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1212_1212;
        tick();
        flush_i = 1'b0; data_rvalid_i = 1'b0;
        check("ffr_stall", 32'(stallreq_o), 0);
        check("ffr_wren", 32'(wb_wren_o), 0);
        check("ffr_discard", 32'(wb_mem_data_o == 32'h1212_1212), 0);

        // Stray response while IDLE is ignored.
        drive(MEMOP_NOP, 1'b1, 1, 32'h55, 0);
        tick();
        stall_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        tick();
        stall_i = 1'b0; data_rvalid_i = 1'b0;
        check("idle_rvalid", wb_wdata_o, 32'h55);

        // Async reset in the middle of WAIT.
        drive(MEMOP_LW, 1'b1, 1, 0, 32'h40);
        tick();
        check("pre_reset_stall", 32'(stallreq_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_stall", 32'(stallreq_o), 0);
        check("areset_wdata", wb_wdata_o, 0);
        check("areset_inst", wb_inst_o, 0);
        check("areset_pc", wb_pc_o, RST_PC);
        check("areset_waddr", wb_waddr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_i = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        tick();
        data_rvalid_i = 1'b0; stall_i = 1'b0;
        check("post_reset_wdata", wb_wdata_o, 0);
        check("post_reset_raw", wb_mem_data_o, 0);
        check("post_reset_stall", 32'(stallreq_o), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
